// File: rtl/elevator_pkg.sv
// Shared types and request-vector helpers for the elevator scheduler.
// Helpers work on the widest supported vector; callers zero-extend.
package elevator_pkg;

   localparam int unsigned MAX_FLOORS  = 16;
   localparam int unsigned MAX_FLOOR_W = 4;
   localparam int unsigned FLOORS_DEF  = 8;
   localparam int unsigned FLOOR_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_e;

   function automatic logic reqs_above(input logic [MAX_FLOORS-1:0]  vec,
                                       input logic [MAX_FLOOR_W-1:0] floor);
      logic r;
      r = 1'b0;
      for (int unsigned f = 0; f < MAX_FLOORS; f++)
         if (f > 32'(floor)) r = r | vec[f[MAX_FLOOR_W-1:0]];
      return r;
   endfunction

   function automatic logic reqs_below(input logic [MAX_FLOORS-1:0]  vec,
                                       input logic [MAX_FLOOR_W-1:0] floor);
      logic r;
      r = 1'b0;
      for (int unsigned f = 0; f < MAX_FLOORS; f++)
         if (f < 32'(floor)) r = r | vec[f[MAX_FLOOR_W-1:0]];
      return r;
   endfunction

   function automatic logic bit_at(input logic [MAX_FLOORS-1:0]  vec,
                                   input logic [MAX_FLOOR_W-1:0] floor);
      return vec[floor];
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter with zero flag; shared by travel and door phases.
// Holds at zero until reloaded.
module elevator_timer #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset)                cnt_q <= '0;
      else if (load_i)           cnt_q <= load_val_i;
      else if (cnt_q != '0)      cnt_q <= cnt_q - W'(1);
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler for the car: travels floor by floor, opens the door at
// served floors and returns one-cycle clear pulses to the request latch.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int unsigned FLOORS        = FLOORS_DEF,
   parameter int unsigned FLOOR_W       = FLOOR_W_DEF,
   parameter int unsigned TRAVEL_CYCLES = 16,
   parameter int unsigned DOOR_CYCLES   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  active_in_levels,
   input  logic [FLOORS-1:0]  active_out_up_levels,
   input  logic [FLOORS-1:0]  active_out_down_levels,
   output logic [FLOORS-1:0]  inactivate_in_levels,
   output logic [FLOORS-1:0]  inactivate_out_up_levels,
   output logic [FLOORS-1:0]  inactivate_out_down_levels,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               moving,
   output logic               dir_up,
   output logic               door_open
);

   localparam int unsigned TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);
   localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

   state_e               state_q, state_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d;
   logic                 dir_q, dir_d;
   logic                 moving_q, moving_d;
   logic                 door_q, door_d;
   logic [FLOORS-1:0]    pin_q, pin_d, pup_q, pup_d, pdn_q, pdn_d;

   logic                 tmr_load_c, tmr_zero_c;
   logic [TMR_W-1:0]     tmr_val_c;

   logic [FLOORS-1:0]     in_v, up_v, dn_v, req_v, oh_c;
   logic [MAX_FLOORS-1:0] in16, up16, dn16, req16;
   logic [MAX_FLOOR_W-1:0] cf_idx, sv_idx;
   logic [FLOOR_W-1:0]   next_floor_c, sv_floor_c;
   logic                 here_c, above_c, below_c, at_end_c;
   logic                 sv_in, sv_up, sv_dn, sv_above, sv_below, sv_end;
   logic                 stop_c, rev_c;
   int unsigned          cf_u, dist_up, dist_dn;

   elevator_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load_c),
      .load_val_i (tmr_val_c),
      .zero_o     (tmr_zero_c)
   );

   // Request view; bits pulsed last cycle are still visible until the latch clears them.
   always_comb begin
      in_v  = active_in_levels       & ~pin_q;
      up_v  = active_out_up_levels   & ~pup_q;
      dn_v  = active_out_down_levels & ~pdn_q;
      req_v = in_v | up_v | dn_v;
      in16  = MAX_FLOORS'(in_v);
      up16  = MAX_FLOORS'(up_v);
      dn16  = MAX_FLOORS'(dn_v);
      req16 = MAX_FLOORS'(req_v);

      cf_idx   = MAX_FLOOR_W'(floor_q);
      cf_u     = 32'(floor_q);
      here_c   = bit_at(req16, cf_idx);
      above_c  = reqs_above(req16, cf_idx);
      below_c  = reqs_below(req16, cf_idx);
      at_end_c = dir_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);

      next_floor_c = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
      sv_floor_c   = (state_q == ST_MOVE) ? next_floor_c : floor_q;
      sv_idx       = MAX_FLOOR_W'(sv_floor_c);
      sv_in        = bit_at(in16, sv_idx);
      sv_up        = bit_at(up16, sv_idx);
      sv_dn        = bit_at(dn16, sv_idx);
      sv_above     = reqs_above(req16, sv_idx);
      sv_below     = reqs_below(req16, sv_idx);
      sv_end       = dir_q ? (sv_floor_c == TOP_FLOOR) : (sv_floor_c == '0);
      oh_c         = FLOORS'(MAX_FLOORS'(1) << sv_idx);

      // Opposite hall call is taken only where the sweep turns around.
      rev_c  = dir_q ? (sv_dn & (~sv_above | sv_end)) : (sv_up & (~sv_below | sv_end));
      stop_c = sv_in | (dir_q ? sv_up : sv_dn) | rev_c;

      dist_up = FLOORS;
      dist_dn = FLOORS;
      for (int unsigned f = 0; f < FLOORS; f++) begin
         if (req16[f[MAX_FLOOR_W-1:0]] && f > cf_u && dist_up == FLOORS) dist_up = f - cf_u;
         if (req16[f[MAX_FLOOR_W-1:0]] && f < cf_u)                      dist_dn = cf_u - f;
      end
   end

   // Next-state, timer control and pulse generation.
   always_comb begin
      state_d    = state_q;
      floor_d    = floor_q;
      dir_d      = dir_q;
      moving_d   = moving_q;
      door_d     = door_q;
      pin_d      = '0;
      pup_d      = '0;
      pdn_d      = '0;
      tmr_load_c = 1'b0;
      tmr_val_c  = TRAVEL_LOAD;

      case (state_q)
         ST_IDLE: begin
            if (here_c) begin
               state_d    = ST_DOOR;
               door_d     = 1'b1;
               tmr_load_c = 1'b1;
               tmr_val_c  = DOOR_LOAD;
               pin_d      = sv_in ? oh_c : '0;
               if (sv_up) begin
                  pup_d = oh_c;
                  dir_d = 1'b1;
               end else if (sv_dn) begin
                  pdn_d = oh_c;
                  dir_d = 1'b0;
               end
            end else if (above_c || below_c) begin
               dir_d      = above_c && (!below_c || dist_up <= dist_dn);
               state_d    = ST_MOVE;
               moving_d   = 1'b1;
               tmr_load_c = 1'b1;
            end
         end

         ST_MOVE: begin
            if (tmr_zero_c) begin
               if (at_end_c) begin
                  state_d  = ST_IDLE;
                  moving_d = 1'b0;
               end else begin
                  floor_d = next_floor_c;
                  if (stop_c) begin
                     state_d    = ST_DOOR;
                     moving_d   = 1'b0;
                     door_d     = 1'b1;
                     tmr_load_c = 1'b1;
                     tmr_val_c  = DOOR_LOAD;
                     pin_d      = sv_in ? oh_c : '0;
                     if (dir_q ? sv_up : sv_dn) begin
                        if (dir_q) pup_d = oh_c;
                        else       pdn_d = oh_c;
                     end else if (rev_c) begin
                        if (dir_q) pdn_d = oh_c;
                        else       pup_d = oh_c;
                        dir_d = ~dir_q;
                     end
                  end else if (sv_end) begin
                     state_d  = ST_IDLE;
                     moving_d = 1'b0;
                  end else begin
                     tmr_load_c = 1'b1;
                  end
               end
            end
         end

         ST_DOOR: begin
            if (sv_in || (dir_q ? sv_up : sv_dn)) begin
               pin_d      = sv_in ? oh_c : '0;
               pup_d      = (dir_q && sv_up)  ? oh_c : '0;
               pdn_d      = (!dir_q && sv_dn) ? oh_c : '0;
               tmr_load_c = 1'b1;
               tmr_val_c  = DOOR_LOAD;
            end else if (tmr_zero_c) begin
               door_d = 1'b0;
               if (dir_q ? above_c : below_c) begin
                  state_d    = ST_MOVE;
                  moving_d   = 1'b1;
                  tmr_load_c = 1'b1;
               end else if (dir_q ? below_c : above_c) begin
                  dir_d      = ~dir_q;
                  state_d    = ST_MOVE;
                  moving_d   = 1'b1;
                  tmr_load_c = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d  = ST_IDLE;
            moving_d = 1'b0;
            door_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         floor_q  <= '0;
         dir_q    <= 1'b1;
         moving_q <= 1'b0;
         door_q   <= 1'b0;
         pin_q    <= '0;
         pup_q    <= '0;
         pdn_q    <= '0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         moving_q <= moving_d;
         door_q   <= door_d;
         pin_q    <= pin_d;
         pup_q    <= pup_d;
         pdn_q    <= pdn_d;
      end
   end

   assign inactivate_in_levels       = pin_q;
   assign inactivate_out_up_levels   = pup_q;
   assign inactivate_out_down_levels = pdn_q;
   assign current_floor              = floor_q;
   assign moving                     = moving_q;
   assign dir_up                     = dir_q;
   assign door_open                  = door_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler; also stands in for the request
// latch by clearing request bits when their clear pulse is seen.
module tb_elevator_scheduler;

   localparam int T    = 16;
   localparam int DOOR = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_r, up_r, dn_r;
   logic [7:0] inact_in, inact_up, inact_dn;
   logic [3:0] cur_floor;
   logic       moving, dir_up, door_open;

   typedef struct {
      int         due;
      logic [3:0] floor;
      logic [7:0] vin;
      logic [7:0] vup;
      logic [7:0] vdn;
      logic       dir;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   elevator_scheduler #(
      .FLOORS        (8),
      .FLOOR_W       (4),
      .TRAVEL_CYCLES (16),
      .DOOR_CYCLES   (32)
   ) dut (
      .clk                        (clk),
      .reset                      (reset),
      .active_in_levels           (in_r),
      .active_out_up_levels       (up_r),
      .active_out_down_levels     (dn_r),
      .inactivate_in_levels       (inact_in),
      .inactivate_out_up_levels   (inact_up),
      .inactivate_out_down_levels (inact_dn),
      .current_floor              (cur_floor),
      .moving                     (moving),
      .dir_up                     (dir_up),
      .door_open                  (door_open)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic push_exp(input int due, input int floor,
                           input logic [7:0] vin, input logic [7:0] vup,
                           input logic [7:0] vdn, input logic dir);
      exp_t e;
      int   i;
      e.due   = due;
      e.floor = 4'(floor);
      e.vin   = vin;
      e.vup   = vup;
      e.vdn   = vdn;
      e.dir   = dir;
      i = 0;
      while (i < exp_q.size() && exp_q[i].due <= due) i++;
      exp_q.insert(i, e);
   endtask

   // Compare any pulse against the oldest expectation, then clear the latched bits.
   task automatic monitor();
      logic [23:0] p;
      exp_t        e;
      p = {inact_in, inact_up, inact_dn};
      if (p != 24'h0) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_pulse", 32'(p), 32'h0);
         end else begin
            e = exp_q.pop_front();
            check_eq("pulse_cycle",  32'(cyc),       32'(e.due));
            check_eq("pulse_in",     32'(inact_in),  32'(e.vin));
            check_eq("pulse_up",     32'(inact_up),  32'(e.vup));
            check_eq("pulse_dn",     32'(inact_dn),  32'(e.vdn));
            check_eq("pulse_floor",  32'(cur_floor), 32'(e.floor));
            check_eq("pulse_dir",    32'(dir_up),    32'(e.dir));
            check_eq("pulse_door",   32'(door_open), 32'h1);
            check_eq("pulse_moving", 32'(moving),    32'h0);
         end
         in_r = in_r & ~inact_in;
         up_r = up_r & ~inact_up;
         dn_r = dn_r & ~inact_dn;
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
         e = exp_q.pop_front();
         check_eq("pulse_missing", 32'(p), 32'({e.vin, e.vup, e.vdn}));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || moving || door_open) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_pending", 32'(exp_q.size()), 32'h0);
      check_eq("drain_idle",    32'({moving, door_open}), 32'h0);
   endtask

   initial begin
      int c;
      reset = 1'b0;
      in_r  = '0;
      up_r  = '0;
      dn_r  = '0;
      repeat (3) tick();
      check_eq("rst_floor",  32'(cur_floor), 32'h0);
      check_eq("rst_dir",    32'(dir_up),    32'h1);
      check_eq("rst_moving", 32'(moving),    32'h0);
      check_eq("rst_door",   32'(door_open), 32'h0);
      check_eq("rst_pulses", 32'({inact_in, inact_up, inact_dn}), 32'h0);
      reset = 1'b1;
      tick();

      // Cabin call at the current floor: door next cycle, held for DOOR cycles.
      in_r[0] = 1'b1;
      push_exp(cyc + 1, 0, 8'h01, 8'h00, 8'h00, 1'b1);
      tick();
      repeat (DOOR - 1) tick();
      check_eq("t1_door_held",   32'(door_open), 32'h1);
      tick();
      check_eq("t1_door_closed", 32'(door_open), 32'h0);
      check_eq("t1_idle",        32'(moving),    32'h0);

      // Cabin call five floors up.
      in_r[5] = 1'b1;
      push_exp(cyc + 1 + 5 * T, 5, 8'h20, 8'h00, 8'h00, 1'b1);
      tick();
      check_eq("t2_moving", 32'(moving), 32'h1);
      check_eq("t2_dir",    32'(dir_up), 32'h1);
      drain(400);
      check_eq("t2_floor",  32'(cur_floor), 32'h5);

      // Back to floor 0.
      in_r[0] = 1'b1;
      push_exp(cyc + 1 + 5 * T, 0, 8'h01, 8'h00, 8'h00, 1'b0);
      drain(400);

      // Up/down hall calls at 3 while heading to 6: up served now, down on return.
      c = cyc;
      in_r[6] = 1'b1;
      push_exp(c + 1 + 6 * T + DOOR, 6, 8'h40, 8'h00, 8'h00, 1'b1);
      repeat (10) tick();
      up_r[3] = 1'b1;
      dn_r[3] = 1'b1;
      push_exp(c + 1 + 3 * T, 3, 8'h00, 8'h08, 8'h00, 1'b1);
      push_exp(c + 1 + 9 * T + 2 * DOOR, 3, 8'h00, 8'h00, 8'h08, 1'b0);
      drain(600);

      // Position at 4, then nearest-first between 1 and 6.
      in_r[4] = 1'b1;
      push_exp(cyc + 1 + T, 4, 8'h10, 8'h00, 8'h00, 1'b1);
      drain(200);
      c = cyc;
      in_r[1] = 1'b1;
      in_r[6] = 1'b1;
      push_exp(c + 1 + 2 * T, 6, 8'h40, 8'h00, 8'h00, 1'b1);
      push_exp(c + 1 + 7 * T + DOOR, 1, 8'h02, 8'h00, 8'h00, 1'b0);
      tick();
      check_eq("t4_dir_first", 32'(dir_up), 32'h1);
      drain(600);

      // Equal distance either way from floor 1: up wins.
      c = cyc;
      in_r[0] = 1'b1;
      in_r[2] = 1'b1;
      push_exp(c + 1 + T, 2, 8'h04, 8'h00, 8'h00, 1'b1);
      push_exp(c + 1 + 3 * T + DOOR, 0, 8'h01, 8'h00, 8'h00, 1'b0);
      tick();
      check_eq("tie_dir", 32'(dir_up), 32'h1);
      drain(400);

      // Hall-down call at the top floor, then a fresh cabin call while the door is open.
      c = cyc;
      dn_r[7] = 1'b1;
      push_exp(c + 1 + 7 * T, 7, 8'h00, 8'h00, 8'h80, 1'b0);
      repeat (1 + 7 * T) tick();
      repeat (4) tick();
      in_r[7] = 1'b1;
      push_exp(cyc + 1, 7, 8'h80, 8'h00, 8'h00, 1'b0);
      tick();
      repeat (DOOR - 1) tick();
      check_eq("t5_door_reload", 32'(door_open), 32'h1);
      tick();
      check_eq("t5_door_closed", 32'(door_open), 32'h0);
      check_eq("t5_dir",         32'(dir_up),    32'h0);
      check_eq("t5_floor",       32'(cur_floor), 32'h7);

      // Reset while travelling down between floors 3 and 2.
      in_r[0] = 1'b1;
      repeat (6 + 4 * T) tick();
      check_eq("t6_floor_pre",  32'(cur_floor), 32'h3);
      check_eq("t6_moving_pre", 32'(moving),    32'h1);
      reset = 1'b0;
      in_r  = '0;
      up_r  = '0;
      dn_r  = '0;
      exp_q.delete();
      tick();
      check_eq("t6_floor",  32'(cur_floor), 32'h0);
      check_eq("t6_moving", 32'(moving),    32'h0);
      check_eq("t6_door",   32'(door_open), 32'h0);
      check_eq("t6_dir",    32'(dir_up),    32'h1);
      check_eq("t6_pulses", 32'({inact_in, inact_up, inact_dn}), 32'h0);
      reset = 1'b1;
      repeat (40) tick();
      check_eq("t6_still_idle", 32'({moving, door_open}), 32'h0);
      check_eq("t6_still_floor", 32'(cur_floor), 32'h0);

      check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Sequencing controller for the car, sitting downstream of the request-latch block. Consumes the latched cabin, hall-up and hall-down request vectors. Runs a SCAN (collective) schedule: moves floor by floor on timers, opens the door at served floors, and returns one-cycle inactivate pulses that clear the served request bits.

Parameters:
FLOORS, 8, number of floors (2..16); width of all request vectors
FLOOR_W, 4, width of floor index (ceil(log2(FLOORS)) minimum; 4 for FLOORS up to 16)
TRAVEL_CYCLES, 16, clock cycles to move one floor (>=2)
DOOR_CYCLES, 32, clock cycles the door stays open (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  reset, synchronous, active-low
active_in_levels  input  FLOORS  latched cabin requests
active_out_up_levels  input  FLOORS  latched hall-up requests
active_out_down_levels  input  FLOORS  latched hall-down requests
inactivate_in_levels  output  FLOORS  one-cycle clear pulses, cabin
inactivate_out_up_levels  output  FLOORS  one-cycle clear pulses, hall-up
inactivate_out_down_levels  output  FLOORS  one-cycle clear pulses, hall-down
current_floor  output  FLOOR_W  floor the car is at or last passed
moving  output  1  car travelling between floors
dir_up  output  1  current/last travel direction (1 = up)
door_open  output  1  door open

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE, current_floor=0, dir_up=1, moving=0, door_open=0.
  - All inactivate outputs=0; timers cleared.
  - Reset mid-travel or mid-door is abandoned immediately; no pulses issued.
- req[f] = in[f] | up[f] | down[f]. above = OR of req[f] for f>current_floor; below = OR for f<current_floor.
- State IDLE:
  - If req[current_floor], go to DOOR next cycle. Pulse serves in, plus up if up is set, otherwise down.
  - Else if above|below:
    - Choose direction: only above -> up; only below -> down; both -> nearest request, tie -> up.
    - Set dir_up, go to MOVE next cycle.
  - Else stay.
- State MOVE:
  - moving=1; timer loads TRAVEL_CYCLES-1 on entry and counts down.
  - At timer==0, current_floor increments (dir_up) or decrements, then the stop test runs on the new floor in the same cycle.
  - Stop test going up at floor f: stop if in[f] | up[f]. Also stop on down[f] when no requests above f, or f==FLOORS-1. Going down: symmetric.
  - Stop -> DOOR. Else reload timer and continue.
  - current_floor never leaves 0..FLOORS-1. At the end floor the stop test is forced true when req[f], else the state returns to IDLE.
- Entry to DOOR:
  - door_open=1, moving=0; door timer loads DOOR_CYCLES-1.
  - Exactly one cycle of inactivate pulses, registered and aligned with the first door_open cycle.
  - Pulses cover in[f] plus the hall bit in the travel direction. If the direction reverses at this floor, the opposite hall bit is pulsed and dir_up flips.
- State DOOR:
  - A new request at current_floor matching in/served direction during DOOR produces a fresh one-cycle pulse for that bit and reloads the door timer.
  - At timer==0, door_open=0 next cycle.
  - If requests remain ahead in dir_up, go to MOVE. Else if requests behind, flip dir_up and go to MOVE. Else IDLE.
- Inactivate pulses are never asserted for bits that are 0 on the inputs; max width one cycle per event.
- Simultaneous request arrival and served pulse on the same bit: the pulse wins in this block. The latch block's set priority re-asserts it; the next stop test sees it.

Decomposition:
- Shared package elevator_pkg:
  - state encoding (IDLE, MOVE, DOOR)
  - FLOORS/FLOOR_W defaults
  - function reqs_above(vec, floor) and reqs_below(vec, floor)
- One natural sub-module: elevator_timer (loadable down-counter with zero flag), instantiated once and shared by travel and door phases.

Test Plan:
1. Reset, then in[0]=1 at floor 0 -> door_open=1 next cycle, inactivate_in_levels=8'h01 for one cycle, IDLE after 32 door cycles.
2. From floor 0 idle, in[5]=1 -> dir_up=1, current_floor reaches 5 after 80 cycles, door_open=1, inactivate_in_levels=8'h20 one cycle.
3. Moving up from 0 to 6, up[3] and down[3] set at t=10 -> stops at 3, pulses only up bit (8'h08); down[3] is served on the return trip with dir_up=0.
4. Car at 4, requests in[1] and in[6] simultaneously -> nearest is 6 (distance 2 vs 3), moves up first, then reverses to 1.
5. down[7] only, car at 0 -> travels to 7 (end-floor stop), pulses inactivate_out_down_levels=8'h80, dir_up=0.
6. Assert reset=0 for one cycle while moving between floors 2 and 3 -> next cycle state IDLE, current_floor=0, all outputs 0, no pulses.
